// File: rtl/mux_ctrl_pkg.sv
// Shared output-mux control definitions: arbiter state encoding and mux select codes.
// The output-mux instantiation imports the same select constants.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ADD = 2'd1,
        GNT_CMP = 2'd2,
        TURN    = 2'd3
    } arb_state_e;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_CMP = 1'b1;

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Granted-cycle counter: clear has priority; clear together with enable loads 1.
module burst_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= CNT_W'(en);
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/output_bus_arbiter.sv
// Round-robin arbiter between the adder and compare paths for the shared output bus,
// with burst limiting and a one-cycle turnaround gap between ownerships.
module output_bus_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic add_req,
    input  logic cmp_req,
    output logic add_gnt,
    output logic cmp_gnt,
    output logic sel,
    output logic out_valid,
    output logic busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_e       state, state_nxt;
    logic             prio_cmp, prio_cmp_nxt;
    logic             sel_nxt;
    logic             cnt_clr, cnt_en, burst_done;
    logic [CNT_W-1:0] burst_cnt;

    burst_counter #(
        .CNT_W (CNT_W)
    ) u_burst_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (burst_cnt)
    );

    assign burst_done = (burst_cnt == CNT_W'(MAX_BURST));
    // Counter restarts at 1 on grant entry and counts every granted cycle.
    assign cnt_clr    = (state == IDLE) || (state == TURN);
    assign cnt_en     = (state_nxt == GNT_ADD) || (state_nxt == GNT_CMP);

    always_comb begin
        state_nxt    = state;
        prio_cmp_nxt = prio_cmp;
        sel_nxt      = sel;
        case (state)
            IDLE: begin
                if (add_req && cmp_req) begin
                    state_nxt = prio_cmp ? GNT_CMP : GNT_ADD;
                end else if (add_req) begin
                    state_nxt = GNT_ADD;
                end else if (cmp_req) begin
                    state_nxt = GNT_CMP;
                end
                if (state_nxt == GNT_ADD) begin
                    sel_nxt = SEL_ADD;
                end else if (state_nxt == GNT_CMP) begin
                    sel_nxt = SEL_CMP;
                end
            end
            GNT_ADD: begin
                if (!add_req || burst_done) begin
                    state_nxt    = TURN;
                    prio_cmp_nxt = 1'b1;
                end
            end
            GNT_CMP: begin
                if (!cmp_req || burst_done) begin
                    state_nxt    = TURN;
                    prio_cmp_nxt = 1'b0;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are flops loaded from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio_cmp  <= 1'b0;
            sel       <= SEL_ADD;
            add_gnt   <= 1'b0;
            cmp_gnt   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prio_cmp  <= prio_cmp_nxt;
            sel       <= sel_nxt;
            add_gnt   <= (state_nxt == GNT_ADD);
            cmp_gnt   <= (state_nxt == GNT_CMP);
            out_valid <= (state_nxt == GNT_ADD) || (state_nxt == GNT_CMP);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_output_bus_arbiter.sv
// Scoreboard bench for output_bus_arbiter: two instances (MAX_BURST=4 and 1) share stimulus
// and are compared every cycle against a cycle model of the arbiter behaviour.
module tb_output_bus_arbiter;

    logic clk;
    logic rst_n;
    logic add_req;
    logic cmp_req;
    logic add_gnt4, cmp_gnt4, sel4, out_valid4, busy4;
    logic add_gnt1, cmp_gnt1, sel1, out_valid1, busy1;

    output_bus_arbiter #(.MAX_BURST(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_req   (add_req),
        .cmp_req   (cmp_req),
        .add_gnt   (add_gnt4),
        .cmp_gnt   (cmp_gnt4),
        .sel       (sel4),
        .out_valid (out_valid4),
        .busy      (busy4)
    );

    output_bus_arbiter #(.MAX_BURST(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_req   (add_req),
        .cmp_req   (cmp_req),
        .add_gnt   (add_gnt1),
        .cmp_gnt   (cmp_gnt1),
        .sel       (sel1),
        .out_valid (out_valid1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] e4;
        logic [4:0] e1;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_add4 = 0, cnt_cmp4 = 0, cnt_add1 = 0;

    // Model state per instance: index 0 = MAX_BURST 4, index 1 = MAX_BURST 1.
    // st: 0 idle, 1 adder granted, 2 compare granted, 3 turnaround.
    int   m_st[2];
    int   m_cnt[2];
    logic m_prio_cmp[2];
    logic m_sel[2];
    int   m_max[2] = '{4, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic a, input logic c, input logic r,
                              output logic [4:0] exp);
        if (!r) begin
            m_st[i] = 0; m_cnt[i] = 0; m_prio_cmp[i] = 1'b0; m_sel[i] = 1'b0;
        end else begin
            case (m_st[i])
                0: begin
                    if (a && c)  m_st[i] = m_prio_cmp[i] ? 2 : 1;
                    else if (a)  m_st[i] = 1;
                    else if (c)  m_st[i] = 2;
                    if (m_st[i] != 0) begin
                        m_sel[i] = (m_st[i] == 2);
                        m_cnt[i] = 1;
                    end
                end
                1: begin
                    if (!a || m_cnt[i] == m_max[i]) begin m_st[i] = 3; m_prio_cmp[i] = 1'b1; end
                    else m_cnt[i]++;
                end
                2: begin
                    if (!c || m_cnt[i] == m_max[i]) begin m_st[i] = 3; m_prio_cmp[i] = 1'b0; end
                    else m_cnt[i]++;
                end
                default: m_st[i] = 0;
            endcase
        end
        // {busy, out_valid, sel, cmp_gnt, add_gnt}
        exp = {m_st[i] != 0, m_st[i] == 1 || m_st[i] == 2, m_sel[i], m_st[i] == 2, m_st[i] == 1};
    endtask

    task automatic step(input logic a, input logic c, input logic r);
        exp_t       e;
        logic [4:0] x;
        add_req = a;
        cmp_req = c;
        rst_n   = r;
        model_step(0, a, c, r, x); e.e4 = x;
        model_step(1, a, c, r, x); e.e1 = x;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got no entry expected one at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("dut4_outs", {27'd0, busy4, out_valid4, sel4, cmp_gnt4, add_gnt4}, {27'd0, e.e4});
            check("dut1_outs", {27'd0, busy1, out_valid1, sel1, cmp_gnt1, add_gnt1}, {27'd0, e.e1});
        end
        check("excl4", {31'd0, add_gnt4 & cmp_gnt4}, 32'd0);
        check("excl1", {31'd0, add_gnt1 & cmp_gnt1}, 32'd0);
        if (add_gnt4) cnt_add4++;
        if (cmp_gnt4) cnt_cmp4++;
        if (add_gnt1) cnt_add1++;
    endtask

    initial begin
        add_req = 1'b0;
        cmp_req = 1'b0;
        rst_n   = 1'b0;

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Adder request held two cycles, then released
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1);

        // Compare-only ownership; sel remains 1 until the next adder grant
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Both requests held from reset: alternating 4-cycle bursts
        step(1'b0, 1'b0, 1'b0);
        cnt_add4 = 0; cnt_cmp4 = 0;
        repeat (20) step(1'b1, 1'b1, 1'b1);
        check("alt_add_cycles", cnt_add4, 8);
        check("alt_cmp_cycles", cnt_cmp4, 6);

        // Reset during the third compare-granted cycle with an adder request pending
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("rst_abort_gnt", {28'd0, add_gnt4, cmp_gnt4, busy4, sel4}, 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Compare request pulsed only during the turnaround cycle
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        cnt_cmp4 = 0;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("turn_req_ignored", cnt_cmp4, 0);

        // Single-cycle bursts: one adder pulse every three cycles
        step(1'b0, 1'b0, 1'b0);
        cnt_add1 = 0;
        repeat (12) step(1'b1, 1'b0, 1'b1);
        check("mb1_pulses", cnt_add1, 4);

        // Random traffic with occasional reset
        for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_bus_arbiter.md
OUTPUT_BUS_ARBITER -- requirements
Module: output_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive granted cycles per ownership (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port add_req, input, 1 bit: adder path requests the output bus (sum/co valid).
REQ-005 SHALL have port cmp_req, input, 1 bit: compare path requests the output bus (com_res valid).
REQ-006 SHALL have port add_gnt, output, 1 bit: adder path owns the bus this cycle.
REQ-007 SHALL have port cmp_gnt, output, 1 bit: compare path owns the bus this cycle.
REQ-008 SHALL have port sel, output, 1 bit: output-mux select; 0 = sum/co, 1 = com_res with upper bits and sel_co high-Z.
REQ-009 SHALL have port out_valid, output, 1 bit: mux output carries granted data this cycle.
REQ-010 SHALL have port busy, output, 1 bit: arbiter is not in IDLE.

Function
REQ-011 SHALL implement states IDLE, GNT_ADD, GNT_CMP and TURN.
REQ-012 SHALL register all outputs: add_gnt = (state==GNT_ADD), cmp_gnt = (state==GNT_CMP), out_valid = add_gnt|cmp_gnt, busy = (state!=IDLE).
REQ-013 SHALL, in IDLE, enter GNT_ADD if only add_req=1, GNT_CMP if only cmp_req=1, and remain in IDLE if neither is set.
REQ-014 SHALL, in IDLE with both requests set, grant the requester not served last (round-robin pointer; pointer reset value favours adder).
REQ-015 SHALL have 1-cycle latency: a request sampled in IDLE produces a grant in the next cycle.
REQ-016 SHALL load sel on the IDLE-to-grant transition only (0 for GNT_ADD, 1 for GNT_CMP) and hold sel unchanged in GNT_*, TURN and IDLE.
REQ-017 SHALL count granted cycles with a burst counter cleared on grant entry, holding 1 in the first granted cycle.
REQ-018 SHALL leave GNT_* for TURN when the owner's req samples 0, or when the burst count equals MAX_BURST, whichever occurs first.
REQ-019 SHALL update the round-robin pointer to the releasing owner on each GNT_*-to-TURN transition.
REQ-020 SHALL stay in TURN exactly 1 cycle with no grant asserted (bus-turnaround gap), then go to IDLE.
REQ-021 SHALL therefore provide a minimum of 2 grant-free cycles (TURN, IDLE) between any two ownerships, including back-to-back ownerships by the same requester.
REQ-022 SHALL ignore requests arriving during TURN until they are sampled in IDLE.
REQ-023 SHALL never assert add_gnt and cmp_gnt in the same cycle.
REQ-024 SHALL, with MAX_BURST=1, grant exactly one cycle per ownership.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set state=IDLE, sel=0, add_gnt=0, cmp_gnt=0, out_valid=0, busy=0, burst count=0 and pointer=adder-first.
REQ-026 SHALL abort an in-progress grant on reset with no TURN cycle, and resume arbitration from IDLE on the first edge with rst_n=1.

Structure
REQ-027 SHALL take the state encoding, SEL_ADD=1'b0 and SEL_CMP=1'b1 from shared package mux_ctrl_pkg, which the output-mux instantiation also uses.
REQ-028 SHALL implement the burst counter as sub-module burst_counter (clear, enable, count output, width sized for MAX_BURST); all other logic is flat.

Verification
REQ-029 SHALL verify: add_req=1 held 2 cycles, then 0 -> add_gnt high for 2 cycles starting 1 cycle after req, sel=0, then TURN, then IDLE.
REQ-030 SHALL verify: add_req and cmp_req both held 1 from reset -> ownership alternates add, cmp, add, each 4 cycles (MAX_BURST=4) with 2-cycle gaps; sel toggles only at grant entry.
REQ-031 SHALL verify: cmp_req=1 only -> cmp_gnt=1, sel=1, out_valid=1; sel stays 1 after release until the next adder grant.
REQ-032 SHALL verify: rst_n=0 in the 3rd GNT_CMP cycle -> all outputs 0 and sel=0 at the next edge; after release, pending add_req is granted 1 cycle later.
REQ-033 SHALL verify: cmp_req pulsed only during TURN -> no grant is issued.
REQ-034 SHALL verify, with MAX_BURST=1 and add_req held 1 -> a 1-cycle add_gnt pulse every 3 cycles, and add_gnt and cmp_gnt are never both 1.
